// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared sizing constants and word/index types for the datapath register file.
//   REG_W    : default data width of one architectural register
//   NUM_REGS : default number of architectural registers
//   XZR_IDX  : default index of the hardwired-zero register
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int REG_W    = 64;
    localparam int NUM_REGS = 32;
    localparam int XZR_IDX  = 31;

    typedef logic [REG_W-1:0]            reg_word_t;
    typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;

endpackage : reg_file_pkg

// File: rtl/reg_word.sv
// -----------------------------------------------------------------------------
// reg_word
// One WIDTH-bit register with a recirculating write enable and an
// asynchronous active-high clear.
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-high clear
//   wr_en  in   1      load d at the next rising edge
//   d      in   WIDTH  next value
//   q      out  WIDTH  stored value
// -----------------------------------------------------------------------------
module reg_word #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: every word is cleared by reset (not left to software) because the
    // pipeline relies on the whole file reading zero straight out of reset.
    // NOTE: non-blocking assignment so all words update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (wr_en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : reg_word

// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
// Parametrised register file: DEPTH words of WIDTH bits, two combinational
// read ports (Rn/Rm) and one synchronous write port (writeback).
// Index ZERO_REG always reads 0 and ignores writes (ZERO_REG >= DEPTH
// disables it). Indices >= DEPTH read 0 and ignore writes.
// Build option: define REG_FILE_BYPASS_EN to forward a same-cycle write to
// a read port addressing the same live register.
// Ports:
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high; clears every register
//   wr_en      in   1       write enable
//   wr_addr    in   ADDR_W  write index
//   wr_data    in   WIDTH   write data
//   rd_addr_a  in   ADDR_W  read port A index
//   rd_data_a  out  WIDTH   read port A data
//   rd_addr_b  in   ADDR_W  read port B index
//   rd_data_b  out  WIDTH   read port B data
// -----------------------------------------------------------------------------
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter  int WIDTH    = REG_W,
    parameter  int DEPTH    = NUM_REGS,
    parameter  int ZERO_REG = XZR_IDX,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b
);

    logic [WIDTH-1:0] w_q [DEPTH];
    logic [WIDTH-1:0] w_mux_a;
    logic [WIDTH-1:0] w_mux_b;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // Storage plus one-hot write decode. Each slot decodes its own enable, so
    // out-of-range addresses match no slot and the zero slot has no storage.
    for (genvar i = 0; i < DEPTH; i++) begin : g_regs
        if (i == ZERO_REG) begin : g_zero
            assign w_q[i] = '0;
        end else begin : g_word
            logic w_we;
            assign w_we = wr_en && (wr_addr == ADDR_W'(i));
            reg_word #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .reset (reset),
                .wr_en (w_we),
                .d     (wr_data),
                .q     (w_q[i])
            );
        end
    end

    // DEPTH:1 read muxes; an address matching no slot falls through to 0.
    // NOTE: defaults first so every path assigns the outputs (no latch).
    always_comb begin
        w_mux_a = '0;
        w_mux_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == ADDR_W'(i)) w_mux_a = w_q[i];
            if (rd_addr_b == ADDR_W'(i)) w_mux_b = w_q[i];
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // A write only forwards if it targets a real, writable slot.
    logic w_wr_live;
    always_comb begin
        w_wr_live = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i != ZERO_REG && wr_addr == ADDR_W'(i)) w_wr_live = wr_en;
        end
    end

    assign w_rd_a = (w_wr_live && wr_addr == rd_addr_a) ? wr_data : w_mux_a;
    assign w_rd_b = (w_wr_live && wr_addr == rd_addr_b) ? wr_data : w_mux_b;
`else
    assign w_rd_a = w_mux_a;
    assign w_rd_b = w_mux_b;
`endif

    // Reset masks the read ports so forwarded write data cannot leak out.
    assign rd_data_a = reset ? '0 : w_rd_a;
    assign rd_data_b = reset ? '0 : w_rd_b;

endmodule : reg_file_param

// File: tb/tb_reg_file_param.sv
// -----------------------------------------------------------------------------
// tb_reg_file_param
// Bench for reg_file_param: a default 64x32 instance (XZR at 31) and a
// 20-deep, 8-bit instance with its zero register at index 10.
// -----------------------------------------------------------------------------
module tb_reg_file_param;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int S_DEPTH = 20;
    localparam int S_ZERO  = 10;

    logic        clk = 1'b0;
    logic        reset;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [63:0] rd_data_a, rd_data_b;

    logic        s_wr_en;
    logic [4:0]  s_wr_addr;
    logic [7:0]  s_wr_data;
    logic [4:0]  s_rd_addr_a, s_rd_addr_b;
    logic [7:0]  s_rd_data_a, s_rd_data_b;

    // Reference state: what each architectural register should hold.
    logic [63:0] m_regs [32];
    logic [7:0]  s_regs [S_DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file_param dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b)
    );

    reg_file_param #(.WIDTH(8), .DEPTH(S_DEPTH), .ZERO_REG(S_ZERO)) dut_s (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (s_wr_en),
        .wr_addr   (s_wr_addr),
        .wr_data   (s_wr_data),
        .rd_addr_a (s_rd_addr_a),
        .rd_data_a (s_rd_data_a),
        .rd_addr_b (s_rd_addr_b),
        .rd_data_b (s_rd_data_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected read of the main file for the current inputs.
    function automatic logic [63:0] exp_rd(input logic [4:0] a);
        if (reset) return 64'h0;
        if (BYP && wr_en && wr_addr == a && a != 5'd31) return wr_data;
        if (a == 5'd31) return 64'h0;
        return m_regs[a];
    endfunction

    function automatic logic [7:0] exp_rd_s(input logic [4:0] a);
        if (reset) return 8'h0;
        if (BYP && s_wr_en && s_wr_addr == a && int'(a) < S_DEPTH && int'(a) != S_ZERO)
            return s_wr_data;
        if (int'(a) >= S_DEPTH || int'(a) == S_ZERO) return 8'h0;
        return s_regs[a];
    endfunction

    // One clock edge: commit the write into the reference, then settle.
    task automatic tick();
        @(posedge clk);
        if (!reset && wr_en && wr_addr != 5'd31) m_regs[wr_addr] = wr_data;
        if (!reset && s_wr_en && int'(s_wr_addr) < S_DEPTH && int'(s_wr_addr) != S_ZERO)
            s_regs[s_wr_addr] = s_wr_data;
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [63:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
        s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rd_addr_a = '0; s_rd_addr_b = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        for (int i = 0; i < S_DEPTH; i++) s_regs[i] = '0;

        // Reset state, and a write while held in reset is ignored.
        #3;
        rd_addr_a = 5'd0; rd_addr_b = 5'd17;
        #1;
        check("rst_rd_a", rd_data_a, 64'h0);
        check("rst_rd_b", rd_data_b, 64'h0);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'hCAFE; rd_addr_a = 5'd4;
        #1;
        check("rst_bypass_masked", rd_data_a, 64'h0);
        tick();
        wr_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_write_dropped", rd_data_a, 64'h0);
        tick();

        // Reset mid-operation clears immediately; a pending write is lost.
        write(5'd5, 64'hDEAD);
        rd_addr_a = 5'd5; rd_addr_b = 5'd6;
        #1;
        check("x5_written", rd_data_a, 64'hDEAD);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 64'h66;
        #1 reset = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        #1;
        check("midrst_x5", rd_data_a, 64'h0);
        check("midrst_x6", rd_data_b, 64'h0);
        wr_en = 1'b0;
        #1 reset = 1'b0;
        tick();
        check("postrst_x5", rd_data_a, 64'h0);
        check("postrst_x6", rd_data_b, 64'h0);

        // Write then read; wr_en=0 holds.
        write(5'd3, 64'h1234_5678_9ABC_DEF0);
        rd_addr_a = 5'd3;
        #1;
        check("x3_write", rd_data_a, 64'h1234_5678_9ABC_DEF0);
        wr_en = 1'b0; wr_addr = 5'd3; wr_data = 64'hFFFF;
        tick();
        check("x3_hold", rd_data_a, 64'h1234_5678_9ABC_DEF0);

        // Zero register ignores writes and always reads 0.
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
        rd_addr_a = 5'd31; rd_addr_b = 5'd31;
        #1;
        check("xzr_pre_a", rd_data_a, 64'h0);
        check("xzr_pre_b", rd_data_b, 64'h0);
        tick();
        wr_en = 1'b0;
        #1;
        check("xzr_post_a", rd_data_a, 64'h0);
        check("xzr_post_b", rd_data_b, 64'h0);

        // Dual read, including both ports on one register.
        write(5'd1, 64'h11);
        write(5'd2, 64'h22);
        rd_addr_a = 5'd1; rd_addr_b = 5'd2;
        #1;
        check("dual_a", rd_data_a, 64'h11);
        check("dual_b", rd_data_b, 64'h22);
        rd_addr_a = 5'd2;
        #1;
        check("same_a", rd_data_a, 64'h22);
        check("same_b", rd_data_b, 64'h22);

        // Same-cycle write/read hazard.
        write(5'd7, 64'hAA);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hBB; rd_addr_a = 5'd7;
        #1;
        check("hazard_pre", rd_data_a, BYP ? 64'hBB : 64'hAA);
        tick();
        wr_en = 1'b0;
        #1;
        check("hazard_post", rd_data_a, 64'hBB);

        // Randomised traffic against the reference.
        for (int n = 0; n < 300; n++) begin
            wr_en     = ($urandom_range(0, 3) != 0);
            wr_addr   = 5'($urandom_range(0, 31));
            wr_data   = {$urandom, $urandom};
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr_b = 5'($urandom_range(0, 31));
            #1;
            check("rand_a", rd_data_a, exp_rd(rd_addr_a));
            check("rand_b", rd_data_b, exp_rd(rd_addr_b));
            tick();
        end
        wr_en = 1'b0;

        // Sweep of the 20-deep, 8-bit file.
        for (int i = 0; i < S_DEPTH; i++) begin
            s_wr_en = 1'b1; s_wr_addr = 5'(i); s_wr_data = 8'(i + 1);
            tick();
        end
        s_wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            s_rd_addr_a = 5'(i); s_rd_addr_b = 5'(31 - i);
            #1;
            check("sweep_a", 64'(s_rd_data_a), 64'(exp_rd_s(s_rd_addr_a)));
            check("sweep_b", 64'(s_rd_data_b), 64'(exp_rd_s(s_rd_addr_b)));
        end
        s_rd_addr_a = 5'd19; s_rd_addr_b = 5'(S_ZERO);
        #1;
        check("sweep_x19", 64'(s_rd_data_a), 64'd20);
        check("sweep_zero", 64'(s_rd_data_b), 64'd0);

        s_wr_en = 1'b1; s_wr_addr = 5'd25; s_wr_data = 8'h5A; s_rd_addr_a = 5'd25;
        #1;
        check("oor_pre", 64'(s_rd_data_a), 64'd0);
        tick();
        s_wr_en = 1'b0;
        #1;
        check("oor_post", 64'(s_rd_data_a), 64'd0);
        for (int i = 0; i < S_DEPTH; i++) begin
            s_rd_addr_b = 5'(i);
            #1;
            check("oor_no_alias", 64'(s_rd_data_b), (i == S_ZERO) ? 64'd0 : 64'(i + 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_reg_file_param
